// File: rtl/decode_rv_pkg.sv
// Shared types for the RV32I decode stage: opcodes, op classes, immediate
// formats and the registered bundle handed to execute.
package decode_rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Code 0 is ILLEGAL so a reset bundle never looks like a real instruction.
  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OP      = 4'd9,
    OP_FENCE   = 4'd10,
    OP_FENCEI  = 4'd11,
    OP_SYSTEM  = 4'd12
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FENCE_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    op_class_t   op;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/decode_rv_imm.sv
// Combinational immediate assembly: selects and sign-extends the immediate
// field of an RV32I word according to its format.
module decode_rv_imm
  import decode_rv_pkg::*;
(
  input  logic [31:0] i_word,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  // Format mux; classes without an immediate yield zero
  always_comb begin
    o_imm = 32'h0;
    case (i_fmt)
      IMM_I: o_imm = {{20{i_word[31]}}, i_word[31:20]};
      IMM_S: o_imm = {{20{i_word[31]}}, i_word[31:25], i_word[11:7]};
      IMM_B: o_imm = {{19{i_word[31]}}, i_word[31], i_word[7], i_word[30:25],
                      i_word[11:8], 1'b0};
      IMM_U: o_imm = {i_word[31:12], 12'h0};
      IMM_J: o_imm = {{11{i_word[31]}}, i_word[31], i_word[19:12], i_word[20],
                      i_word[30:21], 1'b0};
      default: o_imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/decode_rv.sv
// RV32I decode stage: classifies the fetched word, checks legality, drives
// register-file read addresses and holds one decoded bundle for execute.
// A FENCE.I parks the stage until execute redirects with flush_i.
module decode_rv
  import decode_rv_pkg::*;
#(
  parameter int USE_RISCV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] word_i,
  input  logic [29:0] next_ip_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [4:0]  rf_ra1_o,
  output logic [4:0]  rf_ra2_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [3:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        alt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        rd_we_o,
  output logic [31:0] imm_o,
  output logic        illegal_o,
  output logic        fence_i_o,
  input  logic        flush_i
);

  // Only RV32I is decoded; any other setting makes every word illegal.
  localparam bit RV_OK = (USE_RISCV == 1);

  logic        r_valid;
  logic        r_fence;
  decoded_t    r_bundle;
  state_t      r_state;
  state_t      w_state_nxt;
  op_class_t   w_op;
  imm_fmt_t    w_fmt;
  logic        w_we;
  logic        w_alt;
  logic [31:0] w_imm;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_acc;
  decoded_t    w_dec;

  assign w_f3  = word_i[14:12];
  assign w_f7  = word_i[31:25];
  assign w_acc = valid_i & ready_o;

  // Class, legality, immediate format and rd write-enable from opcode/funct
  always_comb begin
    w_op  = OP_ILLEGAL;
    w_fmt = IMM_NONE;
    w_we  = 1'b0;
    w_alt = 1'b0;
    if (RV_OK && word_i[1:0] == 2'b11) begin
      case (word_i[6:0])
        OPC_LUI:   begin w_op = OP_LUI;   w_fmt = IMM_U; w_we = 1'b1; end
        OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = IMM_U; w_we = 1'b1; end
        OPC_JAL:   begin w_op = OP_JAL;   w_fmt = IMM_J; w_we = 1'b1; end
        OPC_JALR:
          if (w_f3 == 3'd0) begin w_op = OP_JALR; w_fmt = IMM_I; w_we = 1'b1; end
        OPC_BRANCH:
          if (w_f3 != 3'd2 && w_f3 != 3'd3) begin w_op = OP_BRANCH; w_fmt = IMM_B; end
        OPC_LOAD:
          if (w_f3 != 3'd3 && w_f3 < 3'd6) begin w_op = OP_LOAD; w_fmt = IMM_I; w_we = 1'b1; end
        OPC_STORE:
          if (w_f3 < 3'd3) begin w_op = OP_STORE; w_fmt = IMM_S; end
        OPC_OPIMM:
          // Shift immediates carry funct7; only SRAI may use 7'h20
          if ((w_f3 == 3'd1) ? (w_f7 == 7'h00) :
              (w_f3 == 3'd5) ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1) begin
            w_op  = OP_OPIMM;
            w_fmt = IMM_I;
            w_we  = 1'b1;
            w_alt = (w_f3 == 3'd1 || w_f3 == 3'd5) & word_i[30];
          end
        OPC_OP:
          // 7'h20 only selects SUB and SRA
          if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) begin
            w_op  = OP_OP;
            w_we  = 1'b1;
            w_alt = word_i[30];
          end
        OPC_MISC:   w_op = (w_f3 == 3'd1) ? OP_FENCEI : OP_FENCE;
        OPC_SYSTEM: begin w_op = OP_SYSTEM; w_we = (w_f3 != 3'd0); end
        default: ;
      endcase
    end
  end

  decode_rv_imm u_imm (
    .i_word (word_i),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  // Pack the decode of word_i into the bundle shape
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = {next_ip_i, 2'b00};
    w_dec.op      = w_op;
    w_dec.funct3  = w_f3;
    w_dec.alt     = w_alt;
    w_dec.rd      = word_i[11:7];
    w_dec.rs1     = word_i[19:15];
    w_dec.rs2     = word_i[24:20];
    w_dec.rd_we   = w_we & (word_i[11:7] != 5'd0);
    w_dec.imm     = w_imm;
    w_dec.illegal = (w_op == OP_ILLEGAL);
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: a FENCE.I parks us until execute redirects
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)                          w_state_nxt = ST_RUN;
    else if (w_acc && w_op == OP_FENCEI)  w_state_nxt = ST_FENCE_WAIT;
  end

  // FSM outputs: handshake ready; flush cycles always swallow the offered word
  always_comb begin
    ready_o = flush_i | ((~r_valid | ready_i) & (r_state == ST_RUN));
  end

  // Bundle register, valid bit and one-shot FENCE.I pulse; flush wins over accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_fence  <= 1'b0;
      r_bundle <= '0;
    end else begin
      r_fence <= 1'b0;
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_acc) begin
        r_bundle <= w_dec;
        r_valid  <= 1'b1;
        r_fence  <= (w_op == OP_FENCEI);
      end else if (ready_i & r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  // RF read addresses track the word being accepted so read data lines up
  // with the bundle next cycle; otherwise keep re-reading the held sources
  always_comb begin
    rf_ra1_o = w_acc ? word_i[19:15] : r_bundle.rs1;
    rf_ra2_o = w_acc ? word_i[24:20] : r_bundle.rs2;
  end

  assign valid_o   = r_valid;
  assign fence_i_o = r_fence;
  assign pc_o      = r_bundle.pc;
  assign op_o      = r_bundle.op;
  assign funct3_o  = r_bundle.funct3;
  assign alt_o     = r_bundle.alt;
  assign rd_o      = r_bundle.rd;
  assign rs1_o     = r_bundle.rs1;
  assign rs2_o     = r_bundle.rs2;
  assign rd_we_o   = r_bundle.rd_we;
  assign imm_o     = r_bundle.imm;
  assign illegal_o = r_bundle.illegal;

endmodule

// File: tb/tb_decode_rv.sv
// Directed bench for decode_rv: reset, decode of several formats, stall,
// flush, FENCE.I sequencing and illegal words.
module tb_decode_rv;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] word_i;
  logic [29:0] next_ip_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rf_ra1_o, rf_ra2_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [3:0]  op_o;
  logic [2:0]  funct3_o;
  logic        alt_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        rd_we_o;
  logic [31:0] imm_o;
  logic        illegal_o;
  logic        fence_i_o;
  logic        flush_i;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] C_ILLEGAL = 4'd0, C_JAL = 4'd3, C_BRANCH = 4'd5,
                         C_STORE = 4'd7, C_OPIMM = 4'd8, C_FENCEI = 4'd11;
  localparam logic [31:0] W_ADDI = 32'hFFF00293, W_JAL = 32'hFFDFF0EF,
                          W_BEQ  = 32'h00208463, W_SW  = 32'h0020A223,
                          W_FNCI = 32'h0000100F;

  always #5 clk_i = ~clk_i;

  decode_rv #(.USE_RISCV(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .word_i(word_i), .next_ip_i(next_ip_i),
    .valid_i(valid_i), .ready_o(ready_o), .rf_ra1_o(rf_ra1_o), .rf_ra2_o(rf_ra2_o),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .op_o(op_o),
    .funct3_o(funct3_o), .alt_o(alt_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_we_o(rd_we_o), .imm_o(imm_o), .illegal_o(illegal_o),
    .fence_i_o(fence_i_o), .flush_i(flush_i)
  );

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b1; word_i = W_SW; next_ip_i = 30'h0;
    ready_i = 1'b1; flush_i = 1'b0;
    #12;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", valid_o); end
    checks++; if (fence_i_o !== 1'b0) begin errors++; $display("FAIL rst_fence got %0h exp 0", fence_i_o); end
    checks++; if (op_o !== 4'd0 || illegal_o !== 1'b0 || imm_o !== 32'h0 || pc_o !== 32'h0)
      begin errors++; $display("FAIL rst_bundle got op=%0h ill=%0h imm=%h pc=%h exp zeros", op_o, illegal_o, imm_o, pc_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", ready_o); end
    checks++; if (rf_ra1_o !== 5'd1 || rf_ra2_o !== 5'd2)
      begin errors++; $display("FAIL rst_rfra got %0d/%0d exp 1/2", rf_ra1_o, rf_ra2_o); end
    valid_i = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
  endtask

  task automatic test_addi();
    valid_i = 1'b1; word_i = W_ADDI; next_ip_i = 30'h10;
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", valid_o); end
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL addi_pc got %h exp 00000040", pc_o); end
    checks++; if (op_o !== C_OPIMM || rd_o !== 5'd5 || rd_we_o !== 1'b1 || illegal_o !== 1'b0)
      begin errors++; $display("FAIL addi_fields got op=%0d rd=%0d we=%0d ill=%0d exp 8/5/1/0", op_o, rd_o, rd_we_o, illegal_o); end
    checks++; if (imm_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", imm_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %0h exp 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1; valid_i = 1'b1; word_i = W_JAL; next_ip_i = 30'h20;
    step();
    word_i = W_BEQ; next_ip_i = 30'h21;
    checks++; if (valid_o !== 1'b1 || op_o !== C_JAL || imm_o !== 32'hFFFFFFFC || rd_o !== 5'd1 || rd_we_o !== 1'b1)
      begin errors++; $display("FAIL b2b_jal got v=%0d op=%0d imm=%h rd=%0d we=%0d exp 1/3/fffffffc/1/1", valid_o, op_o, imm_o, rd_o, rd_we_o); end
    step();
    word_i = W_SW; next_ip_i = 30'h22;
    checks++; if (valid_o !== 1'b1 || op_o !== C_BRANCH || imm_o !== 32'h8 || rd_we_o !== 1'b0 || pc_o !== 32'h84)
      begin errors++; $display("FAIL b2b_beq got v=%0d op=%0d imm=%h we=%0d pc=%h exp 1/5/8/0/84", valid_o, op_o, imm_o, rd_we_o, pc_o); end
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || op_o !== C_STORE || imm_o !== 32'h4 || rd_we_o !== 1'b0 || rs1_o !== 5'd1 || rs2_o !== 5'd2)
      begin errors++; $display("FAIL b2b_sw got v=%0d op=%0d imm=%h we=%0d rs=%0d/%0d exp 1/7/4/0/1/2", valid_o, op_o, imm_o, rd_we_o, rs1_o, rs2_o); end
    step();
  endtask

  task automatic test_stall();
    ready_i = 1'b0; valid_i = 1'b1; word_i = W_SW; next_ip_i = 30'h30;
    step();
    word_i = W_ADDI; next_ip_i = 30'h31;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || op_o !== C_STORE || pc_o !== 32'hC0)
        begin errors++; $display("FAIL stall_hold%0d got rdy=%0d v=%0d op=%0d pc=%h exp 0/1/7/c0", i, ready_o, valid_o, op_o, pc_o); end
      checks++; if (rf_ra1_o !== 5'd1 || rf_ra2_o !== 5'd2)
        begin errors++; $display("FAIL stall_rfra%0d got %0d/%0d exp 1/2", i, rf_ra1_o, rf_ra2_o); end
      step();
    end
    ready_i = 1'b1; #1;
    checks++; if (ready_o !== 1'b1 || rf_ra1_o !== 5'd0 || rf_ra2_o !== 5'd31)
      begin errors++; $display("FAIL stall_release got rdy=%0d ra=%0d/%0d exp 1/0/31", ready_o, rf_ra1_o, rf_ra2_o); end
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || op_o !== C_OPIMM || pc_o !== 32'hC4)
      begin errors++; $display("FAIL stall_next got v=%0d op=%0d pc=%h exp 1/8/c4", valid_o, op_o, pc_o); end
    step();
  endtask

  task automatic test_flush();
    ready_i = 1'b1; valid_i = 1'b1; word_i = W_JAL; next_ip_i = 30'h40; flush_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0d exp 1", ready_o); end
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_kill got %0d exp 0", valid_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_never got %0d exp 0", valid_o); end
  endtask

  task automatic test_fencei();
    ready_i = 1'b1; valid_i = 1'b1; word_i = W_FNCI; next_ip_i = 30'h50;
    step();
    word_i = W_ADDI; next_ip_i = 30'h51;
    #1;
    checks++; if (valid_o !== 1'b1 || fence_i_o !== 1'b1 || op_o !== C_FENCEI || ready_o !== 1'b0)
      begin errors++; $display("FAIL fencei_first got v=%0d f=%0d op=%0d rdy=%0d exp 1/1/11/0", valid_o, fence_i_o, op_o, ready_o); end
    step();
    checks++; if (fence_i_o !== 1'b0 || ready_o !== 1'b0 || valid_o !== 1'b0)
      begin errors++; $display("FAIL fencei_wait got f=%0d rdy=%0d v=%0d exp 0/0/0", fence_i_o, ready_o, valid_o); end
    step();
    checks++; if (ready_o !== 1'b0 || fence_i_o !== 1'b0)
      begin errors++; $display("FAIL fencei_wait2 got rdy=%0d f=%0d exp 0/0", ready_o, fence_i_o); end
    flush_i = 1'b1; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fencei_flushrdy got %0d exp 1", ready_o); end
    step();
    flush_i = 1'b0; valid_i = 1'b0; #1;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
      begin errors++; $display("FAIL fencei_resume got rdy=%0d v=%0d exp 1/0", ready_o, valid_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    words[0] = 32'h00000000; words[1] = 32'hFFFFFFFF; words[2] = 32'h4000F033;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; word_i = words[i]; next_ip_i = 30'h60 + 30'(i);
      step();
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || illegal_o !== 1'b1 || op_o !== C_ILLEGAL || rd_we_o !== 1'b0)
        begin errors++; $display("FAIL illegal%0d got v=%0d ill=%0d op=%0d we=%0d exp 1/1/0/0", i, valid_o, illegal_o, op_o, rd_we_o); end
      step();
    end
  endtask

  task automatic test_reset_stall();
    ready_i = 1'b0; valid_i = 1'b1; word_i = W_FNCI; next_ip_i = 30'h70;
    step();
    rst_ni = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || fence_i_o !== 1'b0 || op_o !== 4'd0 || ready_o !== 1'b1)
      begin errors++; $display("FAIL async_rst got v=%0d f=%0d op=%0d rdy=%0d exp 0/0/0/1", valid_o, fence_i_o, op_o, ready_o); end
    step();
    rst_ni = 1'b1; ready_i = 1'b1; word_i = W_ADDI; next_ip_i = 30'h71;
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || op_o !== C_OPIMM)
      begin errors++; $display("FAIL rst_first_acc got v=%0d op=%0d exp 1/8", valid_o, op_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_fencei();
    test_illegal();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
